// File: rtl/pong_pkg.sv
// Shared types and default geometry for the Pong game engine.
package pong_pkg;

  // Game FSM encoding; values are visible on oState.
  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_POINT = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  // Motion direction along one axis: INC = right / down, DEC = left / up.
  typedef enum logic {
    DIR_INC = 1'b0,
    DIR_DEC = 1'b1
  } dir_t;

  // Default geometry for the 640x480 board.
  localparam int unsigned DEF_COORD_W     = 10;
  localparam int unsigned DEF_H_RES       = 640;
  localparam int unsigned DEF_V_RES       = 480;
  localparam int unsigned DEF_PADDLE_W    = 15;
  localparam int unsigned DEF_PADDLE_H    = 50;
  localparam int unsigned DEF_PADDLE_X0   = 10;
  localparam int unsigned DEF_PADDLE_X1   = 615;
  localparam int unsigned DEF_BALL_W      = 10;
  localparam int unsigned DEF_BALL_H      = 13;
  localparam int unsigned DEF_BALL_STEP   = 1;
  localparam int unsigned DEF_PADDLE_STEP = 1;
  localparam int unsigned DEF_TICK_DIV    = 100000;
  localparam int unsigned DEF_SERVE_TICKS = 120;
  localparam int unsigned DEF_SCORE_W     = 4;
  localparam int unsigned DEF_WIN_SCORE   = 9;

endpackage

// File: rtl/pong_tick_gen.sv
// Game-tick divider: one-cycle oTick pulse every TICK_DIV clock cycles.
module pong_tick_gen #(
  parameter int unsigned TICK_DIV = 100000
) (
  input  logic iclk,
  input  logic irst_n,
  output logic oTick
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t L_LAST = cnt_t'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == L_LAST);
  assign oTick  = w_last;

  // Free-running modulo-TICK_DIV counter.
  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pong_engine.sv
// Two-player Pong game core: serve timing, ball/paddle motion, collision,
// scoring, win detection and a per-pixel overlay for the video path.
module pong_engine
  import pong_pkg::*;
#(
  parameter int unsigned COORD_W     = DEF_COORD_W,
  parameter int unsigned H_RES       = DEF_H_RES,
  parameter int unsigned V_RES       = DEF_V_RES,
  parameter int unsigned PADDLE_W    = DEF_PADDLE_W,
  parameter int unsigned PADDLE_H    = DEF_PADDLE_H,
  parameter int unsigned PADDLE_X0   = DEF_PADDLE_X0,
  parameter int unsigned PADDLE_X1   = DEF_PADDLE_X1,
  parameter int unsigned BALL_W      = DEF_BALL_W,
  parameter int unsigned BALL_H      = DEF_BALL_H,
  parameter int unsigned BALL_STEP   = DEF_BALL_STEP,
  parameter int unsigned PADDLE_STEP = DEF_PADDLE_STEP,
  parameter int unsigned TICK_DIV    = DEF_TICK_DIV,
  parameter int unsigned SERVE_TICKS = DEF_SERVE_TICKS,
  parameter int unsigned SCORE_W     = DEF_SCORE_W,
  parameter int unsigned WIN_SCORE   = DEF_WIN_SCORE
) (
  input  logic               iclk,
  input  logic               irst_n,
  input  logic [1:0]         iUp,
  input  logic [1:0]         iDown,
  input  logic               iServe,
  input  logic [COORD_W-1:0] iX,
  input  logic [COORD_W-1:0] iY,
  output logic [COORD_W-1:0] oBallX,
  output logic [COORD_W-1:0] oBallY,
  output logic [COORD_W-1:0] oPaddleY0,
  output logic [COORD_W-1:0] oPaddleY1,
  output logic [SCORE_W-1:0] oScore0,
  output logic [SCORE_W-1:0] oScore1,
  output logic [1:0]         oState,
  output logic [1:0]         oWinner,
  output logic [2:0]         oPixel
);

  localparam int unsigned SC_W = $clog2(SERVE_TICKS + 1);

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COORD_W:0]   ext_t;    // one spare bit so sums never wrap
  typedef logic [SCORE_W-1:0] score_t;
  typedef logic [SC_W-1:0]    scnt_t;

  localparam ext_t   L_HRES     = ext_t'(H_RES);
  localparam ext_t   L_VRES     = ext_t'(V_RES);
  localparam ext_t   L_PW       = ext_t'(PADDLE_W);
  localparam ext_t   L_PH       = ext_t'(PADDLE_H);
  localparam ext_t   L_PX0      = ext_t'(PADDLE_X0);
  localparam ext_t   L_PX1      = ext_t'(PADDLE_X1);
  localparam ext_t   L_BW       = ext_t'(BALL_W);
  localparam ext_t   L_BH       = ext_t'(BALL_H);
  localparam ext_t   L_BSTEP    = ext_t'(BALL_STEP);
  localparam ext_t   L_PSTEP    = ext_t'(PADDLE_STEP);
  localparam ext_t   L_BX_C     = ext_t'((H_RES - BALL_W) / 2);
  localparam ext_t   L_BY_C     = ext_t'((V_RES - BALL_H) / 2);
  localparam ext_t   L_PY_C     = ext_t'((V_RES - PADDLE_H) / 2);
  localparam ext_t   L_PY_MAX   = ext_t'(V_RES - PADDLE_H);
  localparam ext_t   L_BY_MAX   = ext_t'(V_RES - BALL_H);
  localparam ext_t   L_X0_EDGE  = ext_t'(PADDLE_X0 + PADDLE_W);
  localparam ext_t   L_X1_EDGE  = ext_t'(PADDLE_X1 - BALL_W);
  localparam score_t L_WIN      = score_t'(WIN_SCORE);
  localparam scnt_t  L_SRV_LAST = scnt_t'(SERVE_TICKS - 1);

  logic               w_tick;

  state_t             r_state,    w_state_nxt;
  logic [COORD_W-1:0] r_ball_x,   w_ball_x_nxt;
  logic [COORD_W-1:0] r_ball_y,   w_ball_y_nxt;
  logic [COORD_W-1:0] r_pad_y0,   w_pad_y0_nxt;
  logic [COORD_W-1:0] r_pad_y1,   w_pad_y1_nxt;
  logic [SCORE_W-1:0] r_score0,   w_score0_nxt;
  logic [SCORE_W-1:0] r_score1,   w_score1_nxt;
  dir_t               r_dx,       w_dx_nxt;
  dir_t               r_dy,       w_dy_nxt;
  dir_t               r_srv_dir,  w_srv_dir_nxt;
  logic [SC_W-1:0]    r_srv_cnt,  w_srv_cnt_nxt;

  logic [COORD_W:0]   w_bx, w_by, w_p0, w_p1, w_px, w_py;
  logic               w_ov0, w_ov1;
  logic               w_hit_ball, w_hit_p0, w_hit_p1;

  pong_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .iclk   (iclk),
    .irst_n (irst_n),
    .oTick  (w_tick)
  );

  function automatic coord_t f_move_paddle(input coord_t y, input logic up, input logic dn);
    ext_t   ye;
    coord_t res;
    ye  = ext_t'(y);
    res = y;
    if (up && !dn) begin
      res = (ye < L_PSTEP) ? '0 : coord_t'(ye - L_PSTEP);
    end else if (dn && !up) begin
      res = (ye + L_PSTEP > L_PY_MAX) ? coord_t'(L_PY_MAX) : coord_t'(ye + L_PSTEP);
    end
    return res;
  endfunction

  assign w_bx = ext_t'(r_ball_x);
  assign w_by = ext_t'(r_ball_y);
  assign w_p0 = ext_t'(r_pad_y0);
  assign w_p1 = ext_t'(r_pad_y1);

  assign w_ov0 = (w_by + L_BH > w_p0) && (w_by < w_p0 + L_PH);
  assign w_ov1 = (w_by + L_BH > w_p1) && (w_by < w_p1 + L_PH);

  // State register and game datapath registers.
  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      r_state   <= ST_SERVE;
      r_ball_x  <= coord_t'(L_BX_C);
      r_ball_y  <= coord_t'(L_BY_C);
      r_pad_y0  <= coord_t'(L_PY_C);
      r_pad_y1  <= coord_t'(L_PY_C);
      r_score0  <= '0;
      r_score1  <= '0;
      r_dx      <= DIR_INC;
      r_dy      <= DIR_INC;
      r_srv_dir <= DIR_INC;
      r_srv_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ball_x  <= w_ball_x_nxt;
      r_ball_y  <= w_ball_y_nxt;
      r_pad_y0  <= w_pad_y0_nxt;
      r_pad_y1  <= w_pad_y1_nxt;
      r_score0  <= w_score0_nxt;
      r_score1  <= w_score1_nxt;
      r_dx      <= w_dx_nxt;
      r_dy      <= w_dy_nxt;
      r_srv_dir <= w_srv_dir_nxt;
      r_srv_cnt <= w_srv_cnt_nxt;
    end
  end

  // Next-state, motion, collision and scoring; everything advances on ticks only.
  always_comb begin
    w_state_nxt   = r_state;
    w_ball_x_nxt  = r_ball_x;
    w_ball_y_nxt  = r_ball_y;
    w_pad_y0_nxt  = r_pad_y0;
    w_pad_y1_nxt  = r_pad_y1;
    w_score0_nxt  = r_score0;
    w_score1_nxt  = r_score1;
    w_dx_nxt      = r_dx;
    w_dy_nxt      = r_dy;
    w_srv_dir_nxt = r_srv_dir;
    w_srv_cnt_nxt = r_srv_cnt;

    if (w_tick) begin
      if (r_state != ST_OVER) begin
        w_pad_y0_nxt = f_move_paddle(r_pad_y0, iUp[0], iDown[0]);
        w_pad_y1_nxt = f_move_paddle(r_pad_y1, iUp[1], iDown[1]);
      end

      case (r_state)
        ST_SERVE: begin
          w_ball_x_nxt = coord_t'(L_BX_C);
          w_ball_y_nxt = coord_t'(L_BY_C);
          if (r_srv_cnt == L_SRV_LAST) begin
            w_state_nxt = ST_PLAY;
            w_dx_nxt    = r_srv_dir;
            w_dy_nxt    = DIR_INC;
          end else begin
            w_srv_cnt_nxt = r_srv_cnt + 1'b1;
          end
        end

        ST_PLAY: begin
          if (r_dy == DIR_INC) begin
            if (w_by + L_BH + L_BSTEP >= L_VRES) begin
              w_ball_y_nxt = coord_t'(L_BY_MAX);
              w_dy_nxt     = DIR_DEC;
            end else begin
              w_ball_y_nxt = coord_t'(w_by + L_BSTEP);
            end
          end else begin
            if (w_by < L_BSTEP) begin
              w_ball_y_nxt = '0;
              w_dy_nxt     = DIR_INC;
            end else begin
              w_ball_y_nxt = coord_t'(w_by - L_BSTEP);
            end
          end

          // Left-side tests are rearranged as x <= edge+step so nothing underflows.
          if (r_dx == DIR_DEC) begin
            if ((w_bx <= L_X0_EDGE + L_BSTEP) && (w_bx >= L_X0_EDGE) && w_ov0) begin
              w_ball_x_nxt = coord_t'(L_X0_EDGE);
              w_dx_nxt     = DIR_INC;
            end else if (w_bx < L_BSTEP) begin
              w_score1_nxt  = r_score1 + 1'b1;
              w_srv_dir_nxt = DIR_DEC;
              w_state_nxt   = ST_POINT;
            end else begin
              w_ball_x_nxt = coord_t'(w_bx - L_BSTEP);
            end
          end else begin
            if ((w_bx + L_BW + L_BSTEP >= L_PX1) && (w_bx + L_BW <= L_PX1) && w_ov1) begin
              w_ball_x_nxt = coord_t'(L_X1_EDGE);
              w_dx_nxt     = DIR_DEC;
            end else if (w_bx + L_BW + L_BSTEP >= L_HRES) begin
              w_score0_nxt  = r_score0 + 1'b1;
              w_srv_dir_nxt = DIR_INC;
              w_state_nxt   = ST_POINT;
            end else begin
              w_ball_x_nxt = coord_t'(w_bx + L_BSTEP);
            end
          end
        end

        ST_POINT: begin
          if ((r_score0 == L_WIN) || (r_score1 == L_WIN)) begin
            w_state_nxt = ST_OVER;
          end else begin
            w_state_nxt   = ST_SERVE;
            w_srv_cnt_nxt = '0;
            w_ball_x_nxt  = coord_t'(L_BX_C);
            w_ball_y_nxt  = coord_t'(L_BY_C);
          end
        end

        ST_OVER: begin
          if (iServe) begin
            w_state_nxt   = ST_SERVE;
            w_score0_nxt  = '0;
            w_score1_nxt  = '0;
            w_srv_cnt_nxt = '0;
            w_srv_dir_nxt = DIR_INC;
            w_ball_x_nxt  = coord_t'(L_BX_C);
            w_ball_y_nxt  = coord_t'(L_BY_C);
          end
        end

        default: begin
          w_state_nxt = ST_SERVE;
        end
      endcase
    end
  end

  // Winner flags, one bit per player, only while the game is over.
  always_comb begin
    oWinner = '0;
    if (r_state == ST_OVER) begin
      oWinner = {r_score1 == L_WIN, r_score0 == L_WIN};
    end
  end

  assign w_px = ext_t'(iX);
  assign w_py = ext_t'(iY);

  assign w_hit_ball = (w_px >= w_bx)  && (w_px < w_bx + L_BW) &&
                      (w_py >= w_by)  && (w_py < w_by + L_BH);
  assign w_hit_p0   = (w_px >= L_PX0) && (w_px < L_PX0 + L_PW) &&
                      (w_py >= w_p0)  && (w_py < w_p0 + L_PH);
  assign w_hit_p1   = (w_px >= L_PX1) && (w_px < L_PX1 + L_PW) &&
                      (w_py >= w_p1)  && (w_py < w_p1 + L_PH);

  assign oPixel    = {w_hit_p1, w_hit_p0, w_hit_ball};
  assign oBallX    = r_ball_x;
  assign oBallY    = r_ball_y;
  assign oPaddleY0 = r_pad_y0;
  assign oPaddleY1 = r_pad_y1;
  assign oScore0   = r_score0;
  assign oScore1   = r_score1;
  assign oState    = r_state;

endmodule
